acc_stream_reader: RTL and testbench
====================================

// Module: acc_stream_reader
// PURPOSE
//  Host-side consumer of the accumulator storage byte stream (DQD, DID, DQ, DI interleaved, high byte first).
//  Paces reads with single-cycle ReadEnable pulses and reassembles byte pairs into 16-bit words.
//  Tags each word with its channel and hands it to the host packetiser over a valid/ready interface.
//  Sits in the ReadClock domain between the storage block and the host transmit path.
// PARAMETERS
//  RD_GAP        4     cycles from a ReadEnable pulse to the next DataIn sample; min 3 (producer latency is 2)
//  RECORD_BYTES  1024  bytes per record; must be a multiple of 8 (2 bytes x 4 channels)
// PORTS
//  ReadClock    in   1   single clock for the whole block
//  Reset_n      in   1   asynchronous, active-low reset
//  Arm          in   1   level; host permits a record read
//  DataReady    in   1   storage has a record in progress or available
//  DataIn       in   8   storage byte (registered by the producer)
//  ReadEnable   out  1   single-cycle pulse: current byte consumed
//  WordOut      out  16  {high byte, low byte}
//  WordChannel  out  2   0=DQD 1=DID 2=DQ 3=DI
//  WordValid    out  1   WordOut/WordChannel valid; held until WordReady
//  WordReady    in   1   host accepts word when WordValid & WordReady
//  RecordDone   out  1   one-cycle pulse after final word accepted
//  Truncated    out  1   sticky: last record aborted early; cleared at next record start
//  Busy         out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async, Reset_n=0): all outputs 0, state IDLE, byte count 0, channel 0, rearm flag 1.
//  FSM states: IDLE, SETTLE, SAMPLE, PULSE, EMIT, DONE.
//  - IDLE: if Arm & DataReady & rearm -> SETTLE, gap counter 0, byte count 0, channel 0, byteSel 0, Truncated<=0.
//    rearm sets when DataReady observed 0 in IDLE; clears on leaving IDLE.
//  - SETTLE: count RD_GAP-1 cycles, then SAMPLE. (First byte likewise waits RD_GAP-1 after arming.)
//  - SAMPLE (1 cycle): byteSel=0 -> hi<=DataIn; byteSel=1 -> lo<=DataIn. Next PULSE.
//  - PULSE (1 cycle): ReadEnable=1 this cycle only (registered, asserted on PULSE entry); byte count +1; byteSel toggles.
//    byteSel was 0 -> SETTLE; byteSel was 1 -> EMIT with WordOut={hi,lo} loaded.
//  - EMIT: WordValid=1, WordOut/WordChannel stable until handshake; no ReadEnable while stalled.
//    On handshake: channel <= channel+1 (wraps 3->0); byte count == RECORD_BYTES -> DONE else SETTLE.
//  - DONE: RecordDone=1 for one cycle -> IDLE.
//  Abort: DataReady=0 while in SETTLE/SAMPLE/PULSE -> Truncated<=1, discard partial word, -> IDLE, no RecordDone.
//    DataReady ignored in EMIT (word already captured); checked again on return to SETTLE.
//  Arm dropped mid-record: ignored; record completes. Arm only sampled in IDLE.
//  ReadEnable pulses per complete record = RECORD_BYTES exactly; minimum spacing RD_GAP+1 cycles.
//  Byte count width clog2(RECORD_BYTES)+1; no wrap within a record.
//  DataReady may stay high for a few cycles after the final pulse; rearm prevents a phantom second record.
// TESTING
//  1 Producer model, 128 words/channel, word k of channel c = {c,k[7:0]}, Arm=1, WordReady=1 -> 512 words,
//    WordChannel 0,1,2,3 repeating, WordOut matches model, 1024 ReadEnable pulses, one RecordDone, Truncated=0.
//  2 WordReady=0 for 20 cycles when word 5 presented -> WordOut/WordChannel/WordValid stable, zero ReadEnable
//    pulses during stall; stream resumes and record completes with 512 words.
//  3 DataReady forced 0 after 301st ReadEnable -> Truncated=1, exactly 150 words emitted, no RecordDone,
//    Busy=0; next record clears Truncated and starts with channel 0.
//  4 DataReady held high 3 cycles after final pulse -> no ReadEnable until DataReady seen 0 then 1 again.
//  5 Reset_n low mid-record (after byte 500), no clock edge -> ReadEnable, WordValid, Busy, RecordDone 0 at once;
//    after release, Arm & DataReady start a fresh record at channel 0.
//  6 Arm=0, DataReady=1 for 100 cycles -> no ReadEnable, Busy=0; Arm=1 -> first pulse RD_GAP cycles later.

Source files
------------

// File: rtl/acc_stream_reader.sv
// acc_stream_reader: host-side consumer of the accumulator storage byte stream.
// Reads bytes one at a time, spacing reads by RD_GAP cycles. Each read is acknowledged with a
// single-cycle ReadEnable pulse. Byte pairs (high byte first) become 16-bit words. Each word is
// tagged with its channel (DQD, DID, DQ, DI in rotation) and offered on a valid/ready port.
//
// Ports
//   ReadClock    clock for the whole block
//   Reset_n      asynchronous active-low reset
//   Arm          host permits a record read (sampled only while idle)
//   DataReady    storage has a record in progress or available
//   DataIn       storage byte, registered by the producer (2-cycle latency after ReadEnable)
//   ReadEnable   one-cycle pulse: current byte consumed
//   WordOut      {high byte, low byte}
//   WordChannel  0=DQD 1=DID 2=DQ 3=DI
//   WordValid    word held until WordReady
//   WordReady    host accepts on WordValid & WordReady
//   RecordDone   one-cycle pulse after the final word of a record is accepted
//   Truncated    sticky: last record aborted early; cleared at next record start
//   Busy         high whenever not idle
module acc_stream_reader #(
  parameter int unsigned RD_GAP       = 4,
  parameter int unsigned RECORD_BYTES = 1024
) (
  input  logic        ReadClock,
  input  logic        Reset_n,
  input  logic        Arm,
  input  logic        DataReady,
  input  logic [7:0]  DataIn,
  output logic        ReadEnable,
  output logic [15:0] WordOut,
  output logic [1:0]  WordChannel,
  output logic        WordValid,
  input  logic        WordReady,
  output logic        RecordDone,
  output logic        Truncated,
  output logic        Busy
);

  localparam int unsigned CntW = $clog2(RECORD_BYTES) + 1;
  localparam int unsigned GapW = $clog2(RD_GAP);
  // SETTLE lasts RD_GAP-1 cycles, so the counter stops at RD_GAP-2.
  localparam logic [GapW-1:0] GapLast = GapW'(RD_GAP - 2);
  localparam logic [CntW-1:0] RecLast = CntW'(RECORD_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StPulse,
    StEmit,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]      channel_q, channel_d;
  logic            byte_sel_q, byte_sel_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      lo_q, lo_d;
  logic [15:0]     word_q, word_d;
  logic            rearm_q, rearm_d;
  logic            trunc_q, trunc_d;
  logic            read_enable_q, read_enable_d;
  logic            word_valid_q, word_valid_d;
  logic            record_done_q, record_done_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    gap_d      = '0;
    byte_cnt_d = byte_cnt_q;
    channel_d  = channel_q;
    byte_sel_d = byte_sel_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    word_d     = word_q;
    rearm_d    = rearm_q;
    trunc_d    = trunc_q;

    unique case (state_q)
      StIdle: begin
        // Requiring DataReady to be seen low between records stops a lingering DataReady
        // after the final byte from launching a phantom second record.
        if (!DataReady) rearm_d = 1'b1;
        if (Arm && DataReady && rearm_q) begin
          state_d    = StSettle;
          byte_cnt_d = '0;
          channel_d  = '0;
          byte_sel_d = 1'b0;
          trunc_d    = 1'b0;
          rearm_d    = 1'b0;
        end
      end
      StSettle: begin
        if (!DataReady) begin
          trunc_d = 1'b1;
          state_d = StIdle;
        end else if (gap_q == GapLast) begin
          state_d = StSample;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StSample: begin
        if (!DataReady) begin
          trunc_d = 1'b1;
          state_d = StIdle;
        end else begin
          if (byte_sel_q) lo_d = DataIn;
          else            hi_d = DataIn;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (!DataReady) begin
          trunc_d = 1'b1;
          state_d = StIdle;
        end else begin
          byte_cnt_d = byte_cnt_q + CntW'(1);
          byte_sel_d = ~byte_sel_q;
          if (byte_sel_q) begin
            word_d  = {hi_q, lo_q};
            state_d = StEmit;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StEmit: begin
        // The word is already captured, so DataReady is not checked until back in SETTLE.
        if (WordReady) begin
          channel_d = channel_q + 2'd1;
          state_d   = (byte_cnt_q == RecLast) ? StDone : StSettle;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered decodes of the next state so they drop immediately on reset.
    read_enable_d = (state_d == StPulse);
    word_valid_d  = (state_d == StEmit);
    record_done_d = (state_d == StDone);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge ReadClock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      gap_q         <= '0;
      byte_cnt_q    <= '0;
      channel_q     <= '0;
      byte_sel_q    <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      word_q        <= '0;
      rearm_q       <= 1'b1;
      trunc_q       <= 1'b0;
      read_enable_q <= 1'b0;
      word_valid_q  <= 1'b0;
      record_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      byte_cnt_q    <= byte_cnt_d;
      channel_q     <= channel_d;
      byte_sel_q    <= byte_sel_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      word_q        <= word_d;
      rearm_q       <= rearm_d;
      trunc_q       <= trunc_d;
      read_enable_q <= read_enable_d;
      word_valid_q  <= word_valid_d;
      record_done_q <= record_done_d;
      busy_q        <= busy_d;
    end
  end

  assign ReadEnable  = read_enable_q;
  assign WordOut     = word_q;
  assign WordChannel = channel_q;
  assign WordValid   = word_valid_q;
  assign RecordDone  = record_done_q;
  assign Truncated   = trunc_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_acc_stream_reader.sv
// Bench for acc_stream_reader: a storage producer model feeds bytes from a record image; a
// reference model derives the expected word and channel from the image (word i =
// {byte 2i, byte 2i+1}, channel i mod 4) and checks every accepted word, pulse spacing and
// stall stability, plus record-level counts.
module tb_acc_stream_reader;

  localparam int unsigned RdGap    = 4;
  localparam int unsigned RecBytes = 1024;
  localparam int unsigned RecWords = RecBytes / 2;
  localparam int          Budget   = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        data_ready;
  logic [7:0]  data_in;
  logic        read_enable;
  logic [15:0] word_out;
  logic [1:0]  channel;
  logic        word_valid;
  logic        word_ready;
  logic        record_done;
  logic        truncated;
  logic        busy;

  always #5 clk = ~clk;

  acc_stream_reader #(
    .RD_GAP      (RdGap),
    .RECORD_BYTES(RecBytes)
  ) u_dut (
    .ReadClock  (clk),
    .Reset_n    (rst_n),
    .Arm        (arm),
    .DataReady  (data_ready),
    .DataIn     (data_in),
    .ReadEnable (read_enable),
    .WordOut    (word_out),
    .WordChannel(channel),
    .WordValid  (word_valid),
    .WordReady  (word_ready),
    .RecordDone (record_done),
    .Truncated  (truncated),
    .Busy       (busy)
  );

  // Producer: advances one byte per ReadEnable, presents it two registers later.
  logic [7:0]  mem [RecBytes];
  int unsigned p = 0;
  int unsigned p_base = 0;
  logic [7:0]  stage;

  always @(posedge clk) begin
    if (read_enable) p <= p + 1;
    stage   <= mem[(p - p_base) % RecBytes];
    data_in <= stage;
  end

  int total = 0;
  int bad = 0;
  int unsigned re_count = 0, words_seen = 0, done_count = 0, cyc = 0, last_re_cyc = 0;
  int unsigned re_base = 0, word_base = 0, done_base = 0;
  bit          re_seen_any = 0;
  logic        prev_valid = 0, prev_hs = 0;
  logic [15:0] prev_out = '0;
  logic [1:0]  prev_ch = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_mem(input bit pattern);
    for (int b = 0; b < int'(RecBytes); b++) begin
      if (pattern) mem[b] = (b % 2 == 0) ? 8'((b / 2) % 4) : 8'((b / 2) / 4);
      else         mem[b] = 8'($urandom);
    end
  endtask

  task automatic start_record();
    word_base  = words_seen;
    re_base    = re_count;
    done_base  = done_count;
    p_base     = p;
    data_ready = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_count == done_base && n < Budget) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_done_in_time"}, n < Budget, 1);
  endtask

  task automatic wait_re(input int unsigned target, input string tag);
    int n = 0;
    while (re_count - re_base != target && n < Budget) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_re_reached"}, n < Budget, 1);
  endtask

  task automatic end_checks(input string tag);
    check_eq({tag, "_words"}, words_seen - word_base, RecWords);
    check_eq({tag, "_pulses"}, re_count - re_base, RecBytes);
    check_eq({tag, "_dones"}, done_count - done_base, 1);
    check_eq({tag, "_trunc"}, truncated, 0);
  endtask

  task automatic monitor();
    int unsigned idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (read_enable) begin
        if (re_seen_any) check_eq("re_spacing", (cyc - last_re_cyc) >= RdGap + 1, 1);
        check_eq("re_while_valid", word_valid, 0);
        re_seen_any = 1;
        last_re_cyc = cyc;
        re_count++;
      end
      if (rst_n && prev_valid && !prev_hs) begin
        check_eq("stall_valid", word_valid, 1);
        check_eq("stall_word", word_out, prev_out);
        check_eq("stall_chan", channel, prev_ch);
      end
      if (word_valid && word_ready) begin
        idx = words_seen - word_base;
        if (idx < RecWords) begin
          check_eq("word_out", word_out, {mem[2*idx], mem[2*idx+1]});
          check_eq("word_chan", channel, idx % 4);
        end else begin
          check_eq("word_extra", idx, RecWords - 1);
        end
        words_seen++;
      end
      if (record_done) done_count++;
      prev_valid = word_valid && rst_n;
      prev_hs    = word_valid && word_ready;
      prev_out   = word_out;
      prev_ch    = channel;
    end
  endtask

  task automatic main_seq();
    int          n;
    bit          stalled;
    int unsigned r0;

    rst_n      = 1'b0;
    arm        = 1'b0;
    data_ready = 1'b0;
    word_ready = 1'b1;
    fill_mem(1);
    tick(3);
    check_eq("rst_re", read_enable, 0);
    check_eq("rst_valid", word_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", record_done, 0);
    check_eq("rst_trunc", truncated, 0);
    check_eq("rst_word", word_out, 0);
    check_eq("rst_chan", channel, 0);
    rst_n = 1'b1;
    tick(2);

    // Fixed-pattern record with the host always ready.
    arm = 1'b1;
    start_record();
    wait_done("t1");
    tick(1);
    end_checks("t1");

    // DataReady lingering high after the record must not restart a read.
    tick(20);
    check_eq("t4_no_pulse", re_count - re_base, RecBytes);
    check_eq("t4_busy", busy, 0);
    data_ready = 1'b0;
    tick(2);

    // Random data, random backpressure, long stall on word 5.
    fill_mem(0);
    start_record();
    n = 0;
    stalled = 0;
    while (done_count == done_base && n < Budget) begin
      if (!stalled && word_valid && (words_seen - word_base == 5)) begin
        word_ready = 1'b0;
        r0 = re_count;
        stalled = 1;
        tick(20);
        n += 20;
        check_eq("t2_stall_pulses", re_count - r0, 0);
        check_eq("t2_stall_valid", word_valid, 1);
        word_ready = 1'b1;
      end else begin
        word_ready = ($urandom_range(0, 3) != 0);
      end
      tick(1);
      n++;
    end
    check_eq("t2_done_in_time", n < Budget, 1);
    check_eq("t2_stalled", stalled, 1);
    word_ready = 1'b1;
    tick(1);
    end_checks("t2");

    // Abort after the 301st pulse, then a clean record.
    data_ready = 1'b0;
    tick(2);
    fill_mem(0);
    start_record();
    wait_re(301, "t3");
    data_ready = 1'b0;
    tick(10);
    check_eq("t3_trunc", truncated, 1);
    check_eq("t3_words", words_seen - word_base, 150);
    check_eq("t3_pulses", re_count - re_base, 301);
    check_eq("t3_no_done", done_count - done_base, 0);
    check_eq("t3_busy", busy, 0);
    fill_mem(0);
    start_record();
    tick(2);
    check_eq("t3b_trunc_clr", truncated, 0);
    check_eq("t3b_busy", busy, 1);
    wait_done("t3b");
    tick(1);
    end_checks("t3b");

    // Asynchronous reset in the middle of the 500th pulse.
    data_ready = 1'b0;
    tick(2);
    fill_mem(0);
    start_record();
    wait_re(499, "t5");
    n = 0;
    while (!read_enable && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("t5_pulse_seen", read_enable, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_re_now", read_enable, 0);
    check_eq("t5_valid_now", word_valid, 0);
    check_eq("t5_busy_now", busy, 0);
    check_eq("t5_done_now", record_done, 0);
    tick(3);
    start_record();
    rst_n = 1'b1;
    wait_done("t5b");
    tick(1);
    end_checks("t5b");

    // Arm low keeps the block idle; raising it gives the first pulse RD_GAP cycles after
    // the sampling edge (RD_GAP+1 edges counted from the drive point).
    arm = 1'b0;
    data_ready = 1'b0;
    tick(2);
    fill_mem(0);
    start_record();
    tick(100);
    check_eq("t6_no_pulse", re_count - re_base, 0);
    check_eq("t6_busy", busy, 0);
    arm = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!read_enable && n < 20);
    check_eq("t6_latency", n, RdGap + 1);
    wait_done("t6");
    tick(1);
    end_checks("t6");
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
